mcp3008_responder: RTL



---
 rtl/mcp3008_responder_pkg.sv | 17 +
 rtl/mcp3008_responder_pin_sync.sv | 36 +++
 rtl/mcp3008_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mcp3008_responder_pkg.sv
// rtl/mcp3008_responder_pkg.sv - shared states and MCP3008 constants for the responder
package mcp3008_responder_pkg;

   localparam int CFG_BITS     = 4;
   localparam int NUM_CHANNELS = 8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      RX_CFG,
      SAMPLE,
      TX_MSB,
      TX_LSB,
      TX_ZERO
   } state_t;

endpackage

// File: rtl/mcp3008_responder_pin_sync.sv
// rtl/mcp3008_responder_pin_sync.sv - pin synchronizer with previous-sample edge detect
module mcp3008_responder_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_LEVEL  = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;
   logic [SYNC_STAGES:0]   fill;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {SYNC_STAGES{IDLE_LEVEL}};
         prev  <= IDLE_LEVEL;
         fill  <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pin};
         prev  <= chain[SYNC_STAGES-1];
         fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Edges are masked until the reset idle levels have flushed out of the chain,
   // so a pin already away from its idle level at reset never looks like an edge.
   assign level = chain[SYNC_STAGES-1];
   assign rise  = fill[SYNC_STAGES] & ~prev & level;
   assign fall  = fill[SYNC_STAGES] & prev & ~level;

endmodule

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - SPI target emulating an MCP3008 8-channel ADC
module mcp3008_responder
   import mcp3008_responder_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_BITS   = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cs_n,
   input  logic                              dclk,
   input  logic                              din,
   output logic                              dout,
   output logic                              dout_oe,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0] chan_data,
   output logic [CFG_BITS-1:0]               cfg,
   output logic                              cfg_valid,
   output logic [DATA_BITS-1:0]              sample,
   output logic                              busy
);

   localparam int IDX_W = $clog2(DATA_BITS);

   logic cs_level, cs_rise, cs_fall;
   logic dclk_level, dclk_rise, dclk_fall;
   logic din_level, din_rise, din_fall;
   logic unused_sync;

   mcp3008_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .pin(cs_n), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
   mcp3008_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_dclk_sync (
      .clk(clk), .rst(rst), .pin(dclk), .level(dclk_level), .rise(dclk_rise), .fall(dclk_fall));
   mcp3008_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_din_sync (
      .clk(clk), .rst(rst), .pin(din), .level(din_level), .rise(din_rise), .fall(din_fall));

   assign unused_sync = &{1'b0, cs_level, dclk_level, din_rise, din_fall};

   // Differential: IN+ is {D2,D1,D0}, IN- its pair partner; negative results clamp to zero.
   function automatic logic [DATA_BITS-1:0] select_channel(
      input logic [CFG_BITS-1:0]               c,
      input logic [NUM_CHANNELS*DATA_BITS-1:0] d
   );
      logic [2:0]         pos_ch;
      logic [2:0]         neg_ch;
      logic [DATA_BITS:0] diff;
      pos_ch = c[2:0];
      neg_ch = {c[2:1], ~c[0]};
      diff   = {1'b0, d[int'(pos_ch)*DATA_BITS +: DATA_BITS]}
             - {1'b0, d[int'(neg_ch)*DATA_BITS +: DATA_BITS]};
      if (c[3])
         return d[int'(pos_ch)*DATA_BITS +: DATA_BITS];
      return diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
   endfunction

   state_t                state, state_n;
   logic [CFG_BITS-1:0]   cfg_shift, cfg_shift_n, cfg_n;
   logic [1:0]            bit_cnt, bit_cnt_n;
   logic [IDX_W-1:0]      bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0]  sample_n;
   logic                  dout_n, dout_oe_n, cfg_valid_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cfg_shift <= '0;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         cfg       <= '0;
         cfg_valid <= 1'b0;
         sample    <= '0;
         dout      <= 1'b0;
         dout_oe   <= 1'b0;
      end else begin
         state     <= state_n;
         cfg_shift <= cfg_shift_n;
         bit_cnt   <= bit_cnt_n;
         bit_idx   <= bit_idx_n;
         cfg       <= cfg_n;
         cfg_valid <= cfg_valid_n;
         sample    <= sample_n;
         dout      <= dout_n;
         dout_oe   <= dout_oe_n;
      end
   end

   always_comb begin
      state_n     = state;
      cfg_shift_n = cfg_shift;
      bit_cnt_n   = bit_cnt;
      bit_idx_n   = bit_idx;
      cfg_n       = cfg;
      cfg_valid_n = 1'b0;
      sample_n    = sample;
      dout_n      = dout;
      dout_oe_n   = dout_oe;

      // A cs rise aborts any frame and swallows a coincident dclk edge.
      if (cs_rise && state != IDLE) begin
         state_n   = IDLE;
         dout_n    = 1'b0;
         dout_oe_n = 1'b0;
      end else begin
         case (state)
            IDLE: if (cs_fall) state_n = WAIT_START;
            WAIT_START: if (dclk_rise && din_level) begin
               state_n   = RX_CFG;
               bit_cnt_n = '0;
            end
            RX_CFG: if (dclk_rise) begin
               cfg_shift_n = {cfg_shift[CFG_BITS-2:0], din_level};
               bit_cnt_n   = bit_cnt + 2'd1;
               if (bit_cnt == 2'd3) begin
                  cfg_n       = cfg_shift_n;
                  cfg_valid_n = 1'b1;
                  state_n     = SAMPLE;
               end
            end
            SAMPLE: if (dclk_fall) begin
               sample_n  = select_channel(cfg, chan_data);
               dout_n    = 1'b0;
               dout_oe_n = 1'b1;
               bit_idx_n = IDX_W'(DATA_BITS-1);
               state_n   = TX_MSB;
            end
            TX_MSB: if (dclk_fall) begin
               dout_n = sample[bit_idx];
               if (bit_idx == '0) begin
                  bit_idx_n = IDX_W'(1);
                  state_n   = TX_LSB;
               end else begin
                  bit_idx_n = bit_idx - IDX_W'(1);
               end
            end
            TX_LSB: if (dclk_fall) begin
               dout_n    = sample[bit_idx];
               bit_idx_n = bit_idx + IDX_W'(1);
               if (bit_idx == IDX_W'(DATA_BITS-1)) state_n = TX_ZERO;
            end
            TX_ZERO: if (dclk_fall) dout_n = 1'b0;
            default: state_n = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
